// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - RV32I execute-stage ALU with EX/MEM pipeline register
//
// Purpose: computes the ALU result and the zero / less-than flags
// combinationally from the decoder's ALUOp/Cin/invA/invB/sign encoding and
// the forwarded operands, then registers them with the destination info
// under flush/stall control.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_valid            an instruction is presented this cycle
//   stall, flush        hold the EX/MEM register / load a bubble (flush wins)
//   alu_a, alu_b        operands (post-forwarding / register-or-immediate)
//   ALUOp               000 SLL, 001 SRL, 011 SRA, 100 ADD, 101 AND,
//                       110 OR, 111 XOR, 010 reserved (result 0)
//   Cin, invA, invB     adder carry-in and operand inversion
//   sign                1 = signed compare, 0 = unsigned compare
//   set_lt              result becomes the zero-extended lt flag
//   id_rd, id_we        destination register and write enable
//   ex_valid ... ex_we  registered EX/MEM outputs
module ex_alu_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] alu_a,
   input  logic [DATA_W-1:0] alu_b,
   input  logic [2:0]        ALUOp,
   input  logic              Cin,
   input  logic              invA,
   input  logic              invB,
   input  logic              sign,
   input  logic              set_lt,
   input  logic [RD_W-1:0]   id_rd,
   input  logic              id_we,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_result,
   output logic              ex_zero,
   output logic              ex_lt,
   output logic [RD_W-1:0]   ex_rd,
   output logic              ex_we
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   logic [DATA_W-1:0] a_mod;
   logic [DATA_W-1:0] b_mod;
   logic [DATA_W:0]   sum;
   logic [SH_W-1:0]   shamt;
   logic              overflow;
   logic              lt_flag;
   logic              zero_flag;
   logic [DATA_W-1:0] op_result;
   logic [DATA_W-1:0] alu_result;

   logic              valid_d,  valid_q;
   logic [DATA_W-1:0] result_d, result_q;
   logic              zero_d,   zero_q;
   logic              lt_d,     lt_q;
   logic [RD_W-1:0]   rd_d,     rd_q;
   logic              we_d,     we_q;

   // Datapath: adder and flags are evaluated every cycle, whatever ALUOp is.
   always_comb begin
      a_mod     = invA ? ~alu_a : alu_a;
      b_mod     = invB ? ~alu_b : alu_b;
      sum       = {1'b0, a_mod} + {1'b0, b_mod} + {{DATA_W{1'b0}}, Cin};
      shamt     = alu_b[SH_W-1:0];
      zero_flag = (sum[DATA_W-1:0] == '0);
      // Overflow of the signed add: like-signed inputs, differently-signed sum.
      overflow  = (a_mod[DATA_W-1] == b_mod[DATA_W-1]) &&
                  (sum[DATA_W-1] != a_mod[DATA_W-1]);
      // Unsigned borrow is the inverted carry-out of A + ~B + 1.
      lt_flag   = sign ? (sum[DATA_W-1] ^ overflow) : ~sum[DATA_W];

      op_result = '0;
      case (ALUOp)
         OP_SLL:  op_result = alu_a << shamt;
         OP_SRL:  op_result = alu_a >> shamt;
         OP_SRA:  op_result = $unsigned($signed(alu_a) >>> shamt);
         OP_ADD:  op_result = sum[DATA_W-1:0];
         OP_AND:  op_result = a_mod & b_mod;
         OP_OR:   op_result = a_mod | b_mod;
         OP_XOR:  op_result = a_mod ^ b_mod;
         default: op_result = '0;
      endcase

      alu_result = set_lt ? {{(DATA_W-1){1'b0}}, lt_flag} : op_result;
   end

   // EX/MEM next state: flush beats stall; stall holds; otherwise load.
   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      lt_d     = lt_q;
      rd_d     = rd_q;
      we_d     = we_q;
      if (flush) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
      end else if (!stall) begin
         valid_d  = id_valid;
         result_d = alu_result;
         zero_d   = zero_flag;
         lt_d     = lt_flag;
         rd_d     = id_rd;
         // x0 is hard-wired zero, so a write to it is dropped here.
         we_d     = id_valid & id_we & (id_rd != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         lt_q     <= 1'b0;
         rd_q     <= '0;
         we_q     <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         lt_q     <= lt_d;
         rd_q     <= rd_d;
         we_q     <= we_d;
      end
   end

   assign ex_valid  = valid_q;
   assign ex_result = result_q;
   assign ex_zero   = zero_q;
   assign ex_lt     = lt_q;
   assign ex_rd     = rd_q;
   assign ex_we     = we_q;

endmodule
